// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage.
// Owns the program counter, drives the instruction-memory word address and
// captures the returned instruction into the IF/ID pipeline register under
// stall, flush and branch/jump redirect control.
// Optional performance counters are compiled in when IF_PERF_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] im_address,
    input  logic [31:0] im_instruction,
    output logic [31:0] pc,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instruction,
`ifdef IF_PERF_EN
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count,
`endif
    output logic        ifid_valid
);

    // The PC is always word aligned; the low two bits of the reset address
    // and of redirect targets are dropped.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_plus4;
    logic        load_valid;

    // Sequential successor of the current PC (modulo 2^32, wraps silently).
    assign pc_plus4 = pc + 32'd4;

    // Word index for the asynchronous-read instruction memory.
    assign im_address = {2'b00, pc[31:2]};

    // An IF/ID load of a real instruction happens only on a normal,
    // un-flushed advance.
    assign load_valid = !redirect_valid && !stall && !flush;

    // PC and IF/ID update with priority reset > redirect > stall > normal.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc               <= RESET_PC_ALIGNED;
            ifid_pc          <= 32'h0;
            ifid_pc_plus4    <= 32'h0;
            ifid_instruction <= NOP_WORD;
            ifid_valid       <= 1'b0;
        end else if (redirect_valid) begin
            pc               <= redirect_target & 32'hFFFF_FFFC;
            ifid_pc          <= 32'h0;
            ifid_pc_plus4    <= 32'h0;
            ifid_instruction <= NOP_WORD;
            ifid_valid       <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                ifid_pc          <= 32'h0;
                ifid_pc_plus4    <= 32'h0;
                ifid_instruction <= NOP_WORD;
                ifid_valid       <= 1'b0;
            end
        end else begin
            pc <= pc_plus4;
            if (load_valid) begin
                ifid_pc          <= pc;
                ifid_pc_plus4    <= pc_plus4;
                ifid_instruction <= im_instruction;
                ifid_valid       <= 1'b1;
            end else begin
                ifid_pc          <= 32'h0;
                ifid_pc_plus4    <= 32'h0;
                ifid_instruction <= NOP_WORD;
                ifid_valid       <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_EN
    // Count valid fetches and stalled (non-redirected) cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_count <= 32'h0;
            perf_stall_count <= 32'h0;
        end else begin
            if (load_valid) begin
                perf_fetch_count <= perf_fetch_count + 32'd1;
            end
            if (stall && !redirect_valid) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage (directed plan + random).
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] im_address;
    logic [31:0] im_instruction;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instruction;
    logic        ifid_valid;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_count;
`endif

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    // Reference state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_ip4;
    logic [31:0] m_ins;
    logic        m_val;
    logic [31:0] m_fetch;
    logic [31:0] m_stalls;
    bit          m_known = 0;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .im_address       (im_address),
        .im_instruction   (im_instruction),
        .pc               (pc),
        .ifid_pc          (ifid_pc),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_instruction (ifid_instruction),
`ifdef IF_PERF_EN
        .perf_fetch_count (perf_fetch_count),
        .perf_stall_count (perf_stall_count),
`endif
        .ifid_valid       (ifid_valid)
    );

    // Asynchronous-read instruction memory (256 words, address wraps).
    assign im_instruction = mem[im_address[7:0]];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Fetch word for a byte address as the memory would return it.
    function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
        logic [31:0] idx;
        idx = byte_addr / 4;
        return mem[idx % 256];
    endfunction

    // Apply one edge of the specified fetch-stage rules to the reference state.
    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] rt);
        logic [31:0] cur;
        cur = m_pc;
        if (r) begin
            m_pc = 32'h0; m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0;
            m_fetch = 0; m_stalls = 0; m_known = 1;
        end else if (rv) begin
            m_pc = rt - (rt % 4);
            m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0;
        end else if (s) begin
            m_stalls = m_stalls + 1;
            if (f) begin
                m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0;
            end
        end else begin
            m_pc = cur + 4;
            if (f) begin
                m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0;
            end else begin
                m_ipc = cur; m_ip4 = cur + 4; m_ins = word_at(cur); m_val = 1;
                m_fetch = m_fetch + 1;
            end
        end
    endtask

    task automatic checkOutput();
        check("pc", pc, m_pc);
        check("ifid_pc", ifid_pc, m_ipc);
        check("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
        check("ifid_instruction", ifid_instruction, m_ins);
        check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_val});
`ifdef IF_PERF_EN
        check("perf_fetch_count", perf_fetch_count, m_fetch);
        check("perf_stall_count", perf_stall_count, m_stalls);
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic rv, input logic [31:0] rt);
        reset = r; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
        #1;
        if (m_known) check("im_address", im_address, m_pc / 4);
        @(posedge clock);
        model_edge(r, s, f, rv, rt);
        #1;
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;

        // Reset
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check("reset_pc", pc, 32'h0);
        check("reset_valid", {31'h0, ifid_valid}, 32'h0);

        // Sequential fetch
        applyStimulus(0, 0, 0, 0, 0);
        check("fetch0_ins", ifid_instruction, 32'h2008_0001);
        check("fetch0_pc4", ifid_pc_plus4, 32'h4);
        applyStimulus(0, 0, 0, 0, 0);
        check("fetch1_ins", ifid_instruction, 32'h2009_0002);
        check("fetch1_pc", pc, 32'h8);

        // Stall three cycles at pc=8
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            check("stall_pc", pc, 32'h8);
            check("stall_ins", ifid_instruction, 32'h2009_0002);
        end
        applyStimulus(0, 0, 0, 0, 0);
        check("resume_ins", ifid_instruction, 32'h0109_5020);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
`ifdef IF_PERF_EN
        check("perf_fetch5", perf_fetch_count, 32'd5);
        check("perf_stall3", perf_stall_count, 32'd3);
`endif

        // Redirect beats simultaneous stall
        applyStimulus(0, 1, 0, 1, 32'h40);
        check("redir_pc", pc, 32'h40);
        check("redir_valid", {31'h0, ifid_valid}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        check("redir_ifid_pc", ifid_pc, 32'h40);

        // Flush at pc=4
        applyStimulus(0, 0, 0, 1, 32'h4);
        applyStimulus(0, 0, 1, 0, 0);
        check("flush_pc", pc, 32'h8);
        check("flush_valid", {31'h0, ifid_valid}, 32'h0);

        // Misaligned redirect
        applyStimulus(0, 0, 0, 1, 32'h43);
        check("misalign_pc", pc, 32'h40);

        // PC wrap
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", ifid_pc_plus4, 32'h0);
        check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);

        // Reset during stall + redirect
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 32'h100);
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_valid", {31'h0, ifid_valid}, 32'h0);
`ifdef IF_PERF_EN
        check("rst_perf_fetch", perf_fetch_count, 32'd0);
        check("rst_perf_stall", perf_stall_count, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25,
                          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                          $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the MIPS pipeline. It sits directly upstream of the instruction memory. It owns the program counter and drives the instruction-memory word address. It captures the returned instruction into the IF/ID pipeline register, with stall, flush and branch/jump redirect control from the hazard and branch units.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] ignored.
NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID on bubble/flush (sll $0,$0,0).

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID (load-use hazard)
flush  input  1  replace IF/ID contents with bubble
redirect_valid  input  1  taken branch/jump resolved downstream
redirect_target  input  32  byte address of redirect destination
im_address  output  32  word index to instruction memory = {2'b00, pc[31:2]}
im_instruction  input  32  instruction word returned combinationally by instruction memory
pc  output  32  current fetch PC (byte address)
ifid_pc  output  32  PC of instruction held in IF/ID
ifid_pc_plus4  output  32  ifid_pc + 4
ifid_instruction  output  32  instruction held in IF/ID
ifid_valid  output  1  IF/ID holds a real (non-bubble) instruction

Behaviour:
- Reset (reset=1 at rising edge):
  - pc <= {RESET_PC[31:2],2'b00}.
  - ifid_pc <= 0, ifid_pc_plus4 <= 0, ifid_instruction <= NOP_WORD, ifid_valid <= 0.
  - Reset overrides all other inputs.
- im_address is purely combinational from pc. The memory is asynchronous-read, so the instruction for pc is available in the same cycle.
- Fetch latency: the instruction at pc appears on ifid_* one rising edge after pc is presented.
- Per-edge priority (highest first): reset > redirect_valid > stall > normal.
  - Redirect:
    - pc <= {redirect_target[31:2],2'b00}.
    - IF/ID <= bubble (ifid_valid=0, ifid_instruction=NOP_WORD, ifid_pc/ifid_pc_plus4 <= 0).
    - Redirect overrides a simultaneous stall.
    - Misaligned targets are silently word-aligned.
  - Stall (no redirect):
    - pc holds.
    - IF/ID holds, unless flush=1. In that case IF/ID <= bubble and pc still holds.
  - Normal (no redirect, no stall):
    - pc <= pc + 4.
    - If flush=0: IF/ID <= {pc, pc+4, im_instruction, valid=1}.
    - If flush=1: IF/ID <= bubble.
- Arithmetic: pc + 4 is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- No internal FSM beyond the PC/IF/ID registers. Stall may be asserted for any number of consecutive cycles without loss of the held instruction.
- Reset mid-stall or mid-redirect: the reset values above apply on that edge. The pending redirect is discarded.

Optional Feature:
- Macro: IF_PERF_EN.
- When defined, two extra output ports are added:
  - perf_fetch_count (32): increments on every edge where IF/ID loads a valid instruction (normal case with flush=0).
  - perf_stall_count (32): increments on every edge with stall=1 and redirect_valid=0.
- Both counters clear to 0 on reset and wrap modulo 2^32.
- When the macro is undefined, the ports and counters do not exist and the behaviour above is unchanged.

Test Plan:
- Reset release with RESET_PC=0, memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000 → pc steps 0,4,8,12. ifid_instruction follows one cycle later: 0x20080001 (ifid_pc=0, pc_plus4=4), then 0x20090002. im_address steps 0,1,2.
- Stall held 3 cycles while pc=8 → pc stays 8, ifid_instruction stays 0x20090002, ifid_valid=1. Fetch resumes with 0x01095020 on the first edge after stall drops.
- redirect_valid=1, target=0x40 with stall=1 at the same edge → pc=0x40, ifid_valid=0, ifid_instruction=NOP_WORD. The next edge loads the word at index 16 with ifid_pc=0x40.
- flush=1 alone at pc=4 → pc becomes 8, IF/ID becomes bubble. Misaligned redirect target 0x43 → pc=0x40.
- Wrap: force pc to 0xFFFFFFFC via redirect → next pc = 0x00000000, ifid_pc_plus4 = 0x00000000.
- Reset asserted during stall+redirect → pc=RESET_PC, ifid_valid=0. With IF_PERF_EN: 5 normal fetches plus 3 stall cycles → perf_fetch_count=5, perf_stall_count=3, both 0 after reset.
